// File: rtl/axi_slave_mem.sv
// AXI4 slave with an internal word-addressed memory; independent read and write FSMs, one burst each.
// Latency: wready/bvalid/rvalid one edge after the respective handshake; reads stream one beat per cycle.
// Backpressure: B and R outputs hold while valid && !ready; awready/arready low until the response completes.
// Ports: aclk/areset (async, active-high); AW/W/B write channels; AR/R read channels. lock/cache/prot ignored.
// Define AXI_SLV_WRAP_EN to support WRAP bursts; otherwise burst 2'b10 is answered as an illegal request.
module axi_slave_mem #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awlock,
  input  logic [3:0]              awcache,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arlock,
  input  logic [3:0]              arcache,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int ASZ = $clog2(NB);
  localparam int MW  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic unused_sideband;
  assign unused_sideband = ^{awlock, awcache, awprot, arlock, arcache, arprot};

  // Request legality, evaluated on the address channel and latched with the burst.
  logic aw_illegal, ar_illegal;
  always_comb begin
    aw_illegal = (awsize > 3'(ASZ)) || (awburst == 2'b11);
    ar_illegal = (arsize > 3'(ASZ)) || (arburst == 2'b11);
`ifdef AXI_SLV_WRAP_EN
    if (awburst == 2'b10 && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15})) aw_illegal = 1'b1;
    if (arburst == 2'b10 && !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ar_illegal = 1'b1;
`else
    if (awburst == 2'b10) aw_illegal = 1'b1;
    if (arburst == 2'b10) ar_illegal = 1'b1;
`endif
  end

  // ---------------- write path ----------------
  wstate_t               wstate;
  logic [ADDR_WIDTH-1:0] waddr, wr_next, wr_step;
  logic [7:0]            wlen;
  logic [2:0]            wsize;
  logic [1:0]            wburst;
  logic [8:0]            wcnt;      // saturates at 256, which already exceeds any len+1
  logic                  werr, willegal;
  logic                  wr_inr, wr_beat_err, wr_en;

  assign wr_step     = ADDR_WIDTH'(1) << wsize;
  assign wr_inr      = (waddr >> ASZ) < ADDR_WIDTH'(MEM_DEPTH);
  assign wr_beat_err = !wr_inr || (wlast && wcnt != {1'b0, wlen});
  assign wr_en       = (wstate == W_DATA) && wvalid && wready && !willegal && wr_inr &&
                       (wcnt <= {1'b0, wlen});

`ifdef AXI_SLV_WRAP_EN
  logic [ADDR_WIDTH-1:0] wr_mask;
  assign wr_mask = ((ADDR_WIDTH'(wlen) + ADDR_WIDTH'(1)) << wsize) - ADDR_WIDTH'(1);
`endif

  always_comb begin
    wr_next = waddr;
    if (wburst == 2'b01) wr_next = waddr + wr_step;
`ifdef AXI_SLV_WRAP_EN
    else if (wburst == 2'b10) wr_next = (waddr & ~wr_mask) | ((waddr + wr_step) & wr_mask);
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wstate   <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
      bid      <= '0;
      waddr    <= '0;
      wlen     <= '0;
      wsize    <= '0;
      wburst   <= '0;
      wcnt     <= '0;
      werr     <= 1'b0;
      willegal <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (awvalid && awready) begin
            awready  <= 1'b0;
            wready   <= 1'b1;
            bid      <= awid;
            waddr    <= awaddr;
            wlen     <= awlen;
            wsize    <= awsize;
            wburst   <= awburst;
            wcnt     <= '0;
            willegal <= aw_illegal;
            werr     <= aw_illegal;
            wstate   <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (wvalid && wready) begin
            if (wlast) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bresp  <= (werr || wr_beat_err) ? 2'b10 : 2'b00;
              wstate <= W_RESP;
            end else begin
              werr  <= werr | wr_beat_err;
              waddr <= wr_next;
              if (!wcnt[8]) wcnt <= wcnt + 9'd1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[waddr[ASZ +: MW]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rstate_t               rstate;
  logic [ADDR_WIDTH-1:0] raddr;     // address of the next beat to load
  logic [7:0]            rlen, rcnt;
  logic [2:0]            rsize;
  logic [1:0]            rburst;
  logic                  rillegal;

  // In idle the fetch uses the AR channel directly so beat 0 loads on the AR edge.
  logic [ADDR_WIDTH-1:0] rd_addr, rd_next, rd_step;
  logic [2:0]            rd_size;
  logic [1:0]            rd_burst;
  logic                  rd_illegal, rd_inr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [1:0]            rd_resp;

  always_comb begin
    rd_addr    = raddr;
    rd_size    = rsize;
    rd_burst   = rburst;
    rd_illegal = rillegal;
    if (rstate == R_IDLE) begin
      rd_addr    = araddr;
      rd_size    = arsize;
      rd_burst   = arburst;
      rd_illegal = ar_illegal;
    end
  end

  assign rd_step = ADDR_WIDTH'(1) << rd_size;
  assign rd_inr  = (rd_addr >> ASZ) < ADDR_WIDTH'(MEM_DEPTH);
  assign rd_word = (!rd_illegal && rd_inr) ? mem[rd_addr[ASZ +: MW]] : '0;
  assign rd_resp = (!rd_illegal && rd_inr) ? 2'b00 : 2'b10;

`ifdef AXI_SLV_WRAP_EN
  logic [7:0]            rd_len;
  logic [ADDR_WIDTH-1:0] rd_mask;
  assign rd_len  = (rstate == R_IDLE) ? arlen : rlen;
  assign rd_mask = ((ADDR_WIDTH'(rd_len) + ADDR_WIDTH'(1)) << rd_size) - ADDR_WIDTH'(1);
`endif

  always_comb begin
    rd_next = rd_addr;
    if (rd_burst == 2'b01) rd_next = rd_addr + rd_step;
`ifdef AXI_SLV_WRAP_EN
    else if (rd_burst == 2'b10) rd_next = (rd_addr & ~rd_mask) | ((rd_addr + rd_step) & rd_mask);
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rstate   <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rresp    <= 2'b00;
      rid      <= '0;
      rdata    <= '0;
      raddr    <= '0;
      rlen     <= '0;
      rcnt     <= '0;
      rsize    <= '0;
      rburst   <= '0;
      rillegal <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (arvalid && arready) begin
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rid      <= arid;
            rdata    <= rd_word;
            rresp    <= rd_resp;
            rlast    <= (arlen == 8'd0);
            raddr    <= rd_next;
            rlen     <= arlen;
            rsize    <= arsize;
            rburst   <= arburst;
            rillegal <= ar_illegal;
            rcnt     <= '0;
            rstate   <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              rstate  <= R_IDLE;
            end else begin
              // Next beat is fetched on the same edge that retires the current one.
              rdata <= rd_word;
              rresp <= rd_resp;
              raddr <= rd_next;
              rcnt  <= rcnt + 8'd1;
              rlast <= (rcnt + 8'd1 == rlen);
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_slave_mem.sv
module tb_axi_slave_mem;
  localparam int TMO = 200;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [2:0]  awsize = '0, arsize = '0, awprot = '0, arprot = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0]  awcache = '0, arcache = '0;
  logic        awlock = 1'b0, arlock = 1'b0;
  logic        awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [63:0] wdata = '0, rdata;

  axi_slave_mem dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial forever #5 aclk = ~aclk;

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nbeats;
    logic [7:0]  strb;
    logic [63:0] seed;
    logic [1:0]  exp_bresp;
    bit          tight;
  } vec_t;
  typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [63:0] model_mem [0:1023];
  int          checks = 0;
  int          failures = 0;
  bit          bp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    if (size > 3'd3 || burst == 2'b11) return 1'b0;
    if (burst == 2'b10) begin
`ifdef AXI_SLV_WRAP_EN
      return (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
`else
      return 1'b0;
`endif
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int i);
    logic [31:0] step, win, base;
    step = 32'd1 << size;
    case (burst)
      2'b00: return addr;
      2'b10: begin
        win  = (32'(len) + 32'd1) * step;
        base = addr - (addr % win);
        return base + ((addr - base + 32'(i) * step) % win);
      end
      default: return addr + 32'(i) * step;
    endcase
  endfunction

  // Random ready backpressure, updated away from the edge where the tasks drive.
  initial forever begin
    @(posedge aclk);
    #2;
    rready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    bready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic do_write(input vec_t v);
    logic [31:0] a;
    int          t;
    bexp_t       be, got;
    bit          lg;
    lg = legal(v.len, v.size, v.burst);
    be.id = v.id;
    be.resp = v.exp_bresp;
    bq.push_back(be);
    for (int i = 0; i < v.nbeats; i++) begin
      a = beat_addr(v.addr, v.len, v.size, v.burst, i);
      if (lg && i <= int'(v.len) && a < 32'h2000)
        for (int b = 0; b < 8; b++)
          if (v.strb[b]) model_mem[a[12:3]][8*b +: 8] = (v.seed * 64'(i + 1)) >> (8*b);
    end
    @(posedge aclk); #1;
    awvalid = 1'b1; awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
    t = 0;
    @(negedge aclk);
    while (!awready && t < TMO) begin @(negedge aclk); t++; end
    check("aw_handshake", 64'(awready), 64'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    @(negedge aclk);
    check("wready_after_aw", 64'(wready), 64'd1);
    for (int i = 0; i < v.nbeats; i++) begin
      wvalid = 1'b1; wdata = v.seed * 64'(i + 1); wstrb = v.strb; wlast = (i == v.nbeats - 1);
      t = 0;
      while (!wready && t < TMO) begin @(negedge aclk); t++; end
      @(posedge aclk); #1;
      if (i != v.nbeats - 1) @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge aclk);
    check("bvalid_after_wlast", 64'(bvalid), 64'd1);
    check("wready_after_wlast", 64'(wready), 64'd0);
    t = 0;
    while (!(bvalid && bready) && t < TMO) begin @(negedge aclk); t++; end
    check("b_handshake", 64'(bvalid && bready), 64'd1);
    got = bq.pop_front();
    check("bid", 64'(bid), 64'(got.id));
    check("bresp", 64'(bresp), 64'(got.resp));
    @(posedge aclk);
    @(negedge aclk);
    check("awready_after_b", 64'(awready), 64'd1);
  endtask

  task automatic do_read(input vec_t v);
    logic [31:0] a;
    rexp_t       e;
    int          t, cyc;
    bit          lg, done, stalled;
    logic [63:0] stall_dat;
    lg = legal(v.len, v.size, v.burst);
    for (int i = 0; i <= int'(v.len); i++) begin
      a = beat_addr(v.addr, v.len, v.size, v.burst, i);
      e.id   = v.id;
      e.data = (lg && a < 32'h2000) ? model_mem[a[12:3]] : 64'd0;
      e.resp = (lg && a < 32'h2000) ? 2'b00 : 2'b10;
      e.last = (i == int'(v.len));
      rq.push_back(e);
    end
    @(posedge aclk); #1;
    arvalid = 1'b1; arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
    t = 0;
    @(negedge aclk);
    while (!arready && t < TMO) begin @(negedge aclk); t++; end
    check("ar_handshake", 64'(arready), 64'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    cyc = 0; done = 1'b0; stalled = 1'b0; stall_dat = '0;
    while (!done && cyc < TMO) begin
      @(negedge aclk);
      cyc++;
      if (cyc == 1) check("rvalid_after_ar", 64'(rvalid), 64'd1);
      if (stalled) check("r_stable_while_stalled", rdata, stall_dat);
      stalled = rvalid && !rready;
      stall_dat = rdata;
      if (rvalid && rready && rq.size() != 0) begin
        e = rq.pop_front();
        check("rid", 64'(rid), 64'(e.id));
        check("rdata", rdata, e.data);
        check("rresp", 64'(rresp), 64'(e.resp));
        check("rlast", 64'(rlast), 64'(e.last));
        done = e.last;
      end
    end
    check("r_burst_done", 64'(done), 64'd1);
    if (v.tight) check("r_burst_cycles", 64'(cyc), 64'(int'(v.len) + 1));
    rq.delete();
    @(posedge aclk);
    @(negedge aclk);
    check("arready_after_rlast", 64'(arready), 64'd1);
  endtask

  vec_t vecs[15];
  vec_t w, r;

  initial begin
    vecs[0]  = '{1'b1, 4'd3, 32'h40,   8'd3, 3'd3, 2'b01, 4, 8'hFF, 64'h11, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 4'd3, 32'h40,   8'd3, 3'd3, 2'b01, 0, 8'h00, 64'h0,  2'b00, 1'b1};
    vecs[2]  = '{1'b1, 4'd1, 32'h0,    8'd0, 3'd3, 2'b01, 1, 8'hFF, 64'h0,  2'b00, 1'b0};
    vecs[3]  = '{1'b1, 4'd1, 32'h0,    8'd0, 3'd3, 2'b01, 1, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0};
    vecs[4]  = '{1'b0, 4'd1, 32'h0,    8'd0, 3'd3, 2'b01, 0, 8'h00, 64'h0,  2'b00, 1'b1};
    vecs[5]  = '{1'b1, 4'd2, 32'h0,    8'd3, 3'd3, 2'b01, 4, 8'hFF, 64'h1000, 2'b00, 1'b0};
    vecs[6]  = '{1'b0, 4'd5, 32'h18,   8'd3, 3'd3, 2'b10, 0, 8'h00, 64'h0,  2'b00, 1'b1};
    vecs[7]  = '{1'b1, 4'd4, 32'h1FF8, 8'd1, 3'd3, 2'b01, 2, 8'hFF, 64'hA5, 2'b10, 1'b0};
    vecs[8]  = '{1'b0, 4'd4, 32'h1FF8, 8'd1, 3'd3, 2'b01, 0, 8'h00, 64'h0,  2'b00, 1'b1};
    vecs[9]  = '{1'b1, 4'd6, 32'h100,  8'd3, 3'd3, 2'b01, 2, 8'hFF, 64'h77, 2'b10, 1'b0};
    vecs[10] = '{1'b0, 4'd6, 32'h100,  8'd1, 3'd3, 2'b01, 0, 8'h00, 64'h0,  2'b00, 1'b1};
    vecs[11] = '{1'b1, 4'd7, 32'h200,  8'd0, 3'd3, 2'b01, 1, 8'hFF, 64'h5A, 2'b00, 1'b0};
    vecs[12] = '{1'b1, 4'd7, 32'h200,  8'd0, 3'd3, 2'b11, 1, 8'hFF, 64'h99, 2'b10, 1'b0};
    vecs[13] = '{1'b1, 4'd8, 32'h300,  8'd2, 3'd3, 2'b00, 3, 8'hFF, 64'h10, 2'b00, 1'b0};
    vecs[14] = '{1'b0, 4'd8, 32'h300,  8'd1, 3'd3, 2'b00, 0, 8'h00, 64'h0,  2'b00, 1'b1};

    #1 areset = 1'b1;
    @(negedge aclk);
    check("rst_ctrl", 64'({awready, wready, bvalid, arready, rvalid, rlast}), 64'd0);
    check("rst_ids_resp", 64'({bresp, rresp, bid, rid}), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    check("ready_before_first_edge", 64'({awready, arready}), 64'd0);
    @(negedge aclk);
    check("ready_after_first_edge", 64'({awready, arready}), 64'd3);

    foreach (vecs[i]) begin
      if (vecs[i].wr) do_write(vecs[i]);
      else do_read(vecs[i]);
    end
    // Illegal size, narrow INCR within one word, then 0x200 unchanged by the illegal write.
    do_read('{1'b0, 4'd9, 32'h200, 8'd0, 3'd4, 2'b01, 0, 8'h00, 64'h0, 2'b00, 1'b1});
    do_read('{1'b0, 4'd9, 32'h40,  8'd1, 3'd2, 2'b01, 0, 8'h00, 64'h0, 2'b00, 1'b1});
    do_read('{1'b0, 4'd9, 32'h200, 8'd0, 3'd3, 2'b01, 0, 8'h00, 64'h0, 2'b00, 1'b1});

    // Concurrent bursts on disjoint regions with random ready backpressure.
    bp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w = '{1'b1, 4'(k + 10), 32'h800 + 32'(k) * 32'h100, 8'($urandom_range(0, 7)), 3'd3, 2'b01,
            0, 8'hFF, {$urandom, $urandom}, 2'b00, 1'b0};
      w.nbeats = int'(w.len) + 1;
      r = '{1'b0, 4'd3, 32'h40, 8'd3, 3'd3, 2'b01, 0, 8'h00, 64'h0, 2'b00, 1'b0};
      fork
        do_write(w);
        do_read(r);
      join
      w.wr = 1'b0;
      do_read(w);
    end
    bp_en = 1'b0;
    repeat (2) @(posedge aclk);

    // Reset in the middle of a read burst.
    @(posedge aclk); #1;
    arvalid = 1'b1; arid = 4'd9; araddr = 32'h40; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01;
    begin
      int t;
      t = 0;
      @(negedge aclk);
      while (!arready && t < TMO) begin @(negedge aclk); t++; end
      check("mid_ar_handshake", 64'(arready), 64'd1);
    end
    @(posedge aclk); #1 arvalid = 1'b0;
    repeat (2) begin
      @(negedge aclk);
      check("mid_rvalid", 64'(rvalid), 64'd1);
      check("mid_no_rlast", 64'(rlast), 64'd0);
    end
    @(posedge aclk); #1 areset = 1'b1;
    #1;
    check("rst_mid_rvalid", 64'({rvalid, rlast, arready}), 64'd0);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("rst_mid_arready_pre", 64'(arready), 64'd0);
    @(negedge aclk);
    check("rst_mid_arready_post", 64'(arready), 64'd1);
    check("rst_mid_quiet", 64'({rvalid, rlast}), 64'd0);
    do_read('{1'b0, 4'd3, 32'h40, 8'd3, 3'd3, 2'b01, 0, 8'h00, 64'h0, 2'b00, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

AXI4 slave responder with an internal word-addressed memory. It is the target end of the AXI master interface used by the lpddr bench, and it stands in for the LPDDR controller during bring-up. It accepts write bursts on AW/W and returns B, accepts read bursts on AR and returns R. The read and write paths run independently and concurrently, with one outstanding transaction per direction.

## Interface
- ID_WIDTH, 4, width of awid/bid/arid/rid
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 64, data bus width in bits (power of two, ≥ 32)
- MEM_DEPTH, 1024, number of DATA_WIDTH words (power of two)
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address; awlock, awcache, awprot accepted and ignored
- awvalid in 1, awready out 1  write address handshake
- wdata  in  DATA_WIDTH, wstrb in DATA_WIDTH/8, wlast in 1  write beat
- wvalid in 1, wready out 1  write data handshake
- bid out ID_WIDTH, bresp out 2 (00 OKAY, 10 SLVERR), bvalid out 1, bready in 1  write response
- arid/araddr/arlen/arsize/arburst  in  as AW; arlock, arcache, arprot ignored
- arvalid in 1, arready out 1  read address handshake
- rid out ID_WIDTH, rdata out DATA_WIDTH, rresp out 2, rlast out 1, rvalid out 1, rready in 1  read data

## Operation
- Word index: addr / (DATA_WIDTH/8). A beat is out of range when the index is ≥ MEM_DEPTH.
- Next address per beat:
  - FIXED: unchanged.
  - INCR: addr + 2^size, with the full ADDR_WIDTH sum and no 4 KB check.
  - WRAP: increments within the aligned window of (len+1)·2^size bytes.
- Illegal request (size > log2(DATA_WIDTH/8), burst 11, or WRAP with len not in {1,3,7,15}): the whole burst completes with SLVERR and no memory access. Reads return rdata = 0.
- Write FSM:
  - W_IDLE: awready=1. AW handshake latches id/addr/len/size/burst and moves to W_DATA.
  - W_DATA: wready=1. Each handshake writes the bytes enabled by wstrb to the current word, unless the request was illegal, the beat is out of range, or the beat count exceeds len+1. It then advances the address.
  - The wlast handshake moves to W_RESP.
  - W_RESP: bvalid=1, bid = latched id. The B handshake returns to W_IDLE.
- bresp = SLVERR if any of: illegal request, any beat out of range, or wlast not on beat len+1. Otherwise bresp = OKAY. The burst ends only on wlast.
- Read FSM:
  - R_IDLE: arready=1. AR handshake loads the rdata register with beat 0 and moves to R_DATA.
  - R_DATA: rvalid=1. On an R handshake with rlast=0, the next beat is loaded into the rdata register on the same edge. On rlast the FSM returns to R_IDLE.
  - rlast=1 when the beat count equals len. rresp is per beat: SLVERR for an out-of-range beat or an illegal request.
- Memory contents are not reset.

## Timing
- Reset values:
  - awready, wready, bvalid, arready, rvalid, rlast: 0.
  - bresp, rresp, bid, rid, rdata: 0.
  - awready and arready rise on the first edge after areset falls.
- Write:
  - AW handshake at edge N: wready=1 from N+1.
  - wlast handshake at edge M: bvalid=1 from M+1, wready=0 from M+1.
  - B handshake at edge K: awready=1 from K+1.
- Read:
  - AR handshake at edge N: rvalid=1 with beat 0 from N+1.
  - With rready held high, one beat per cycle.
  - Last-beat handshake at edge K: arready=1 from K+1.
- Outputs stay stable while valid and not ready. The slave never drops valid before the handshake.
- Same word read and written on the same edge: the read returns the old data.
- areset asserted mid-burst: both FSMs return to IDLE immediately, the partial burst is dropped, and no response is issued. Memory keeps any beats already written.

## Configuration
- AXI_SLV_WRAP_EN defined: WRAP bursts are supported as described above.
- AXI_SLV_WRAP_EN undefined: burst 10 is treated as an illegal request (SLVERR, no memory access), and the wrap logic is not compiled.

## Test plan
- Reset, then idle: all outputs 0 during reset; awready=arready=1 on the first edge after release.
- INCR write id=3, addr 0x40, len 3, size 3, data 0x11..0x44, wstrb 0xFF, then INCR read of the same range -> bresp=00 bid=3; read returns 0x11,0x22,0x33,0x44 with rlast on beat 4, 4 consecutive cycles with rready high.
- Write addr 0x0, data 0xFFFF_FFFF_FFFF_FFFF, wstrb 0x0F, over existing 0 -> read returns 0x0000_0000_FFFF_FFFF.
- WRAP read addr 0x18, len 3, size 3 (AXI_SLV_WRAP_EN defined) -> beat addresses 0x18, 0x00, 0x08, 0x10. Without the macro -> 4 beats of SLVERR, rdata 0.
- Write at addr MEM_DEPTH·8−8, INCR len 1 -> first beat stored, second beat suppressed, bresp=10. Also: wlast on beat 2 of len 3 -> bresp=10, burst ends at beat 2.
- Random bready/rready backpressure with concurrent read and write bursts; areset pulsed mid-read -> rvalid=0 immediately, arready=1 one edge after release, no stray rlast.
